kamikaze_lsu_wb: RTL and testbench
==================================

# kamikaze_lsu_wb

Load/store and writeback stage, directly downstream of the execute stage. It takes the ALU result, destination register and write-enable, plus a memory-op code and store data. It runs any data-memory access over a req/ack bus and delivers one registered register-file write per retired instruction. While a bus access is outstanding it stalls the pipeline upstream.

## Interface
Parameters:
- none (XLEN fixed at 32; op codes come from `riscv_defines.v`)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- valid_i  in  1  execute presents an instruction this cycle
- result_i  in  32  ALU result; effective address for memory ops
- store_data_i  in  32  rs2 value for stores
- mem_op_i  in  4  `MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW`
- rf_rd_i  in  5  destination register
- rf_rd_we_i  in  1  destination write request
- stall_o  out  1  stage busy; upstream must hold all inputs
- mem_req_o  out  1  bus request, held until ack
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  word address, {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_rdata_i  in  32  read data, valid with ack
- mem_ack_i  in  1  access complete
- rf_we_o  out  1  register-file write strobe
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- misalign_o  out  1  one-cycle pulse: misaligned access dropped

## Operation
- FSM states: IDLE and WAIT_ACK. `stall_o` = (state == WAIT_ACK), decoded from registered state only.
- Accept: `valid_i && !stall_o`.
- Accepted `MEM_NONE`:
  - Next cycle: `rf_we_o` = `rf_rd_we_i && rf_rd_i != 0`.
  - Next cycle: `rf_waddr_o` = `rf_rd_i`, `rf_wdata_o` = `result_i`.
- Accepted memory op, aligned:
  - Aligned means LH/LHU/SH have addr[0]=0, and LW/SW have addr[1:0]=0.
  - Latch the op, byte offset, rd and rd_we; move to WAIT_ACK.
  - Drive `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o` from registers. They stay stable until ack.
- Byte enables:
  - SB/LB/LBU: 4'b0001 shifted left by addr[1:0].
  - SH/LH/LHU: 4'b0011 shifted left by addr[1:0].
  - SW/LW: 4'b1111.
- Store data is replicated across lanes:
  - SB: {4{d[7:0]}}.
  - SH: {2{d[15:0]}}.
  - SW: d.
- WAIT_ACK with `mem_ack_i`=1:
  - Drop `mem_req_o` at the next edge and return to IDLE.
  - For loads: select the lane by the latched offset, then sign- or zero-extend to 32 bits.
  - Load write: `rf_we_o` = latched rd_we && rd != 0, registered on the same edge.
  - Stores never write the register file.
- Misaligned memory op:
  - No bus request and no register write.
  - `misalign_o` pulses 1 cycle after accept.
  - Stay in IDLE.
- `rf_we_o` and `misalign_o` are single-cycle pulses; at most one per retired instruction.
- `mem_ack_i` while `mem_req_o`=0 is ignored.
- `valid_i`=0 in IDLE: no action; `rf_we_o`=0 next cycle.

## Timing
- Reset (rst_i=0 at an edge): state IDLE; all outputs 0.
  - This covers stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o and misalign_o.
- Reset mid-access: `mem_req_o` falls at that edge and the pending load's write is discarded.
- ALU op latency: 1 cycle, accept edge to `rf_we_o`. Back-to-back ALU ops give full throughput.
- Memory-op latency:
  - `mem_req_o` rises at the edge after accept (cycle N+1).
  - If ack is seen in cycle N+k, the register write and the `stall_o` deassert occur at edge N+k+1.
  - Minimum load latency is 2 cycles.
- Ack in the first request cycle is legal (zero-wait memory).
- Back-to-back memory ops have a 1-cycle IDLE gap. Throughput is one access per 2 cycles minimum.

## Structure
- Add `MEM_*` op codes (4-bit) to `riscv_defines.v` next to the `ALU_*` codes, shared with decode.
- Sub-module `kamikaze_lsu_align` is purely combinational and holds three functions:
  - store BE/data replication and the misalignment check, from op and addr[1:0];
  - load lane extract and extension, from op, offset and rdata.
- The top level holds the FSM and all registers.

## Test plan
- ALU writeback: accept result_i=0x0000_1234, rd=5, we=1 → next cycle rf_we_o=1, waddr=5, wdata=0x0000_1234. Repeat with rd=0 → rf_we_o stays 0.
- LB sign: LB at addr 0x103, ack after 3 wait cycles, rdata=0x80FF_0000 → mem_addr_o=0x100, be=4'b1000, stall_o high 4 cycles, wdata=0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080.
- SH: SH addr 0x202, data 0xABCD_5678 → be=4'b1100, wdata=0x5678_5678, mem_we_o=1, no rf_we_o.
- Zero-wait: LW addr 0x10, ack in first req cycle, rdata=0xDEAD_BEEF → req high exactly 1 cycle; rf_we_o at the 2nd edge after accept.
- Misaligned: LW at 0x0000_0006 → misalign_o one-cycle pulse, mem_req_o never rises, rf_we_o stays 0.
- Reset mid-access: assert rst_i during WAIT_ACK, then ack on the following cycle → req and stall drop at the reset edge; no rf_we_o; stray ack ignored.

Source files
------------

// File: rtl/kamikaze_lsu_wb_pkg.sv
// Shared definitions for the kamikaze load/store + writeback stage.
// The memory-op codes are shared with decode.
package kamikaze_lsu_wb_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
            MEM_SB, MEM_SH, MEM_SW: is_mem_op = 1'b1;
            default:                is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store_op = 1'b1;
            default:                is_store_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kamikaze_lsu_align.sv
// Combinational lane logic: store byte-enables/replication, alignment check,
// and load lane extraction with sign/zero extension.
module kamikaze_lsu_align
    import kamikaze_lsu_wb_pkg::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        st_misalign_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    // Packs {be, wdata}; loads reuse the byte-enable half only.
    function automatic logic [35:0] store_lanes(input logic [3:0] op,
                                                input logic [1:0] off,
                                                input logic [31:0] d);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: store_lanes = {4'b0001 << off, {4{d[7:0]}}};
            MEM_LH, MEM_LHU, MEM_SH: store_lanes = {4'b0011 << off, {2{d[15:0]}}};
            MEM_LW, MEM_SW:          store_lanes = {4'b1111, d};
            default:                 store_lanes = 36'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: misaligned = off[0];
            MEM_LW, MEM_SW:          misaligned = (off != 2'b00);
            default:                 misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0] op,
                                                input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (op)
            MEM_LB:  load_extend = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: load_extend = {24'd0, lane[7:0]};
            MEM_LH:  load_extend = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: load_extend = {16'd0, lane[15:0]};
            MEM_LW:  load_extend = rdata;
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign {st_be_o, st_wdata_o} = store_lanes(st_op_i, st_off_i, st_data_i);
    assign st_misalign_o         = misaligned(st_op_i, st_off_i);
    assign ld_data_o             = load_extend(ld_op_i, ld_off_i, ld_rdata_i);

endmodule

// File: rtl/kamikaze_lsu_wb.sv
// Load/store and writeback stage: runs one req/ack data access at a time and
// produces a single registered register-file write per retired instruction.
module kamikaze_lsu_wb
    import kamikaze_lsu_wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [4:0]  rf_rd_i,
    input  logic        rf_rd_we_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        misalign_o
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        misalign_q, misalign_d;

    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic        st_misalign_s;
    logic [31:0] ld_data_s;

    kamikaze_lsu_align u_align (
        .st_op_i       (mem_op_i),
        .st_off_i      (result_i[1:0]),
        .st_data_i     (store_data_i),
        .st_be_o       (st_be_s),
        .st_wdata_o    (st_wdata_s),
        .st_misalign_o (st_misalign_s),
        .ld_op_i       (op_q),
        .ld_off_i      (off_q),
        .ld_rdata_i    (mem_rdata_i),
        .ld_data_o     (ld_data_s)
    );

    // Next-state and output-register computation.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!valid_i) begin
                    state_d = ST_IDLE;
                end else if (!is_mem_op(mem_op_i)) begin
                    rf_we_d    = rf_rd_we_i && (rf_rd_i != 5'd0);
                    rf_waddr_d = rf_rd_i;
                    rf_wdata_d = result_i;
                end else if (st_misalign_s) begin
                    misalign_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_ACK;
                    req_d   = 1'b1;
                    we_d    = is_store_op(mem_op_i);
                    addr_d  = {result_i[31:2], 2'b00};
                    be_d    = st_be_s;
                    wdata_d = st_wdata_s;
                    op_d    = mem_op_i;
                    off_d   = result_i[1:0];
                    rd_d    = rf_rd_i;
                    rd_we_d = rf_rd_we_i;
                end
            end
            ST_WAIT_ACK: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rf_we_d    = rd_we_q && (rd_q != 5'd0);
                        rf_waddr_d = rd_q;
                        rf_wdata_d = ld_data_s;
                    end else begin
                        rf_we_d = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            op_q       <= 4'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            rd_we_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall_o     = (state_q == ST_WAIT_ACK);
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_kamikaze_lsu_wb.sv
// Bench for kamikaze_lsu_wb: instructions schedule expected per-cycle events
// (bus activity, rf writes, misalign pulses) that one negedge process checks.
module tb_kamikaze_lsu_wb;
    import kamikaze_lsu_wb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] result_i;
    logic [31:0] store_data_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  rf_rd_i;
    logic        rf_rd_we_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        misalign_o;

    always #5 clk_i = ~clk_i;

    kamikaze_lsu_wb dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .result_i(result_i),
        .store_data_i(store_data_i), .mem_op_i(mem_op_i), .rf_rd_i(rf_rd_i),
        .rf_rd_we_i(rf_rd_we_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .misalign_o(misalign_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    bus_t        busy_tab [int];
    logic [36:0] rfw_tab  [int];
    bit          mis_tab  [int];
    bit          rstz_tab [int];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference rules: access size, lanes, replication and extension by arithmetic.
    function automatic int m_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic m_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [1:0] off);
        int v;
        v = ((1 << m_size(op)) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        if (m_size(op) == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        else if (m_size(op) == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        else return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        sz   = m_size(op);
        v    = rdata >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (((op == MEM_LB) || (op == MEM_LH)) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk_i) begin
        if (checking) begin
            if (rstz_tab.exists(cyc))
                chk("reset_outputs", {stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
                     mem_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, misalign_o}, 128'd0);
            chk("stall", stall_o, busy_tab.exists(cyc));
            chk("mem_req", mem_req_o, busy_tab.exists(cyc));
            if (busy_tab.exists(cyc)) begin
                chk("mem_addr", mem_addr_o, busy_tab[cyc].addr);
                chk("mem_be", mem_be_o, busy_tab[cyc].be);
                chk("mem_we", mem_we_o, busy_tab[cyc].we);
                if (busy_tab[cyc].we) chk("mem_wdata", mem_wdata_o, busy_tab[cyc].wdata);
            end
            chk("rf_we", rf_we_o, rfw_tab.exists(cyc));
            if (rfw_tab.exists(cyc)) begin
                chk("rf_waddr", rf_waddr_o, rfw_tab[cyc][36:32]);
                chk("rf_wdata", rf_wdata_o, rfw_tab[cyc][31:0]);
            end
            chk("misalign", misalign_o, mis_tab.exists(cyc));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i     = 1'b0;
        result_i    = $urandom;
        mem_op_i    = 4'($urandom_range(0, 8));
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        step();
        mem_ack_i = 1'b0;
    endtask

    // Presents one instruction, holds it while the stage is busy, answers the bus.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we, input int w,
                         input logic [31:0] rdata, input bit pin, input logic [31:0] pin_val,
                         input bit pinb, input bus_t pin_bus);
        int   a;
        int   sz;
        bus_t b;
        mem_ack_i    = 1'b0;
        valid_i      = 1'b1;
        mem_op_i     = op;
        result_i     = addr;
        store_data_i = sd;
        rf_rd_i      = rd;
        rf_rd_we_i   = we;
        a  = cyc + 1;
        sz = m_size(op);
        if (sz == 0) begin
            if (we && rd != 5'd0) rfw_tab[a] = {rd, pin ? pin_val : addr};
            step();
        end else if ((int'(addr[1:0]) % sz) != 0) begin
            mis_tab[a] = 1'b1;
            step();
        end else begin
            b = pinb ? pin_bus : '{addr & 32'hFFFF_FFFC, m_be(op, addr[1:0]), m_store(op),
                                   m_wdata(op, sd)};
            for (int c = a; c <= a + w; c++) busy_tab[c] = b;
            if (!m_store(op) && we && rd != 5'd0)
                rfw_tab[a + w + 1] = {rd, pin ? pin_val : m_load(op, addr[1:0], rdata)};
            step();
            repeat (w) step();
            mem_ack_i   = 1'b1;
            mem_rdata_i = rdata;
            step();
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
        end
    endtask

    initial begin
        int a;
        rst_i        = 1'b0;
        valid_i      = 1'b0;
        result_i     = 32'd0;
        store_data_i = 32'd0;
        mem_op_i     = 4'd0;
        rf_rd_i      = 5'd0;
        rf_rd_we_i   = 1'b0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = 32'd0;
        rstz_tab[1]  = 1'b1;
        rstz_tab[2]  = 1'b1;
        step();
        checking = 1'b1;
        step();
        rst_i = 1'b1;
        idle();

        // Directed cases with hand-computed expectations.
        issue(MEM_NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 32'd0, 1'b1, 32'h0000_1234, 1'b0, '0);
        issue(MEM_NONE, 32'h0000_1234, 32'd0, 5'd0, 1'b1, 0, 32'd0, 1'b1, 32'h0000_1234, 1'b0, '0);
        issue(MEM_LB, 32'h0000_0103, 32'd0, 5'd6, 1'b1, 3, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80,
              1'b1, '{32'h0000_0100, 4'b1000, 1'b0, 32'd0});
        issue(MEM_LBU, 32'h0000_0103, 32'd0, 5'd6, 1'b1, 3, 32'h80FF_0000, 1'b1, 32'h0000_0080,
              1'b1, '{32'h0000_0100, 4'b1000, 1'b0, 32'd0});
        issue(MEM_SH, 32'h0000_0202, 32'hABCD_5678, 5'd7, 1'b1, 1, 32'd0, 1'b0, 32'd0,
              1'b1, '{32'h0000_0200, 4'b1100, 1'b1, 32'h5678_5678});
        issue(MEM_LW, 32'h0000_0010, 32'd0, 5'd3, 1'b1, 0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF,
              1'b1, '{32'h0000_0010, 4'b1111, 1'b0, 32'd0});
        issue(MEM_LW, 32'h0000_0006, 32'd0, 5'd4, 1'b1, 0, 32'd0, 1'b0, 32'd0, 1'b0, '0);
        idle();

        // Reset during WAIT_ACK, followed by a stray ack.
        valid_i    = 1'b1;
        mem_op_i   = MEM_LW;
        result_i   = 32'h0000_0040;
        rf_rd_i    = 5'd9;
        rf_rd_we_i = 1'b1;
        a = cyc + 1;
        busy_tab[a] = '{32'h0000_0040, 4'b1111, 1'b0, 32'd0};
        step();
        rst_i        = 1'b0;
        valid_i      = 1'b0;
        rstz_tab[a + 1] = 1'b1;
        step();
        rst_i       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        step();
        mem_ack_i = 1'b0;
        idle();

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            issue(4'($urandom_range(0, 8)), $urandom, $urandom, rd, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4)), $urandom, 1'b0, 32'd0, 1'b0, '0);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        idle();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
